// File: rtl/plb_stage_host.sv
// Host-side stage initiator and BRAM responder for the EKF-SLAM core.
// A stage FSM drives stage_val and the operands; a shared memory serves the core's PLB port and a host port.
module plb_stage_host #(
   parameter int PLB_AW = 10,
   parameter int DW     = 32,
   parameter int TO_W   = 16
) (
   input  logic              clk,
   input  logic              sys_rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_stage,
   input  logic [DW-1:0]     cmd_a,
   input  logic [DW-1:0]     cmd_b,
   input  logic [TO_W-1:0]   timeout_lim,
   output logic [2:0]        stage_val,
   input  logic [2:0]        stage_rdy,
   output logic [DW-1:0]     vlr,
   output logic [DW-1:0]     alpha,
   output logic [DW-1:0]     rk,
   output logic [DW-1:0]     phi,
   output logic              busy,
   output logic              done,
   output logic              err,
   input  logic              PLB_en,
   input  logic              PLB_we,
   input  logic [31:0]       PLB_addr,
   input  logic [DW-1:0]     PLB_din,
   output logic [DW-1:0]     PLB_dout,
   input  logic              hst_en,
   input  logic              hst_we,
   input  logic [PLB_AW-1:0] hst_addr,
   input  logic [DW-1:0]     hst_din,
   output logic [DW-1:0]     hst_dout,
   output logic              hst_ack
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GAP} state_t;

   state_t            state_q, state_d;
   logic [2:0]        sel_q, sel_d;
   logic [TO_W-1:0]   cnt_q, cnt_d;
   logic [2:0]        stage_val_q, stage_val_d;
   logic [DW-1:0]     vlr_q, vlr_d, alpha_q, alpha_d, rk_q, rk_d, phi_q, phi_d;
   logic              done_q, done_d, err_q, err_d;
   logic [DW-1:0]     plb_dout_q, plb_dout_d, hst_dout_q, hst_dout_d;
   logic              hst_ack_q, hst_ack_d;
   logic              rdy_sel;

   logic [DW-1:0]     mem [0:(1<<PLB_AW)-1];
   logic [PLB_AW-1:0] paddr, mem_wa;
   logic [DW-1:0]     mem_wd;
   logic              plb_rd, plb_wr, hst_gnt, mem_we;

   // Upper core address bits alias onto the memory; they are intentionally dropped.
   logic unused_addr_hi;
   assign unused_addr_hi = ^PLB_addr[31:PLB_AW];

   assign cmd_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign stage_val = stage_val_q;
   assign vlr       = vlr_q;
   assign alpha     = alpha_q;
   assign rk        = rk_q;
   assign phi       = phi_q;
   assign done      = done_q;
   assign err       = err_q;
   assign PLB_dout  = plb_dout_q;
   assign hst_dout  = hst_dout_q;
   assign hst_ack   = hst_ack_q;

   assign rdy_sel = |(stage_rdy & sel_q);

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      cnt_d       = cnt_q;
      stage_val_d = stage_val_q;
      vlr_d       = vlr_q;
      alpha_d     = alpha_q;
      rk_d        = rk_q;
      phi_d       = phi_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               if (cmd_stage == 2'd3) begin
                  err_d = 1'b1;
               end else begin
                  sel_d       = 3'b001 << cmd_stage;
                  stage_val_d = 3'b001 << cmd_stage;
                  cnt_d       = '0;
                  state_d     = S_WAIT;
                  if (cmd_stage == 2'd0) begin
                     vlr_d   = cmd_a;
                     alpha_d = cmd_b;
                  end else begin
                     rk_d  = cmd_a;
                     phi_d = cmd_b;
                  end
               end
            end
         end
         S_WAIT: begin
            if (rdy_sel) begin
               stage_val_d = 3'b000;
               done_d      = 1'b1;
               state_d     = S_GAP;
            end else if ((timeout_lim != '0) && (cnt_q == timeout_lim - TO_W'(1))) begin
               stage_val_d = 3'b000;
               err_d       = 1'b1;
               state_d     = S_GAP;
            end else begin
               cnt_d = cnt_q + TO_W'(1);
            end
         end
         S_GAP: begin
            // Wait for the core to drop its completion level before taking a new command.
            if (!rdy_sel) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign paddr  = PLB_addr[PLB_AW-1:0];
   assign plb_rd = PLB_en & ~PLB_we;
   assign plb_wr = PLB_en & PLB_we;
   // The ack cycle is excluded so a host still holding hst_en is not served twice.
   assign hst_gnt = hst_en & ~PLB_en & ~hst_ack_q;
   assign mem_we  = plb_wr | (hst_gnt & hst_we);
   assign mem_wa  = PLB_en ? paddr : hst_addr;
   assign mem_wd  = PLB_en ? PLB_din : hst_din;

   always_comb begin
      plb_dout_d = plb_dout_q;
      hst_dout_d = hst_dout_q;
      hst_ack_d  = hst_gnt;
      if (plb_rd) plb_dout_d = mem[paddr];
      if (hst_gnt && !hst_we) hst_dout_d = mem[hst_addr];
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_wa] <= mem_wd;
   end

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= S_IDLE;
         sel_q       <= '0;
         cnt_q       <= '0;
         stage_val_q <= '0;
         vlr_q       <= '0;
         alpha_q     <= '0;
         rk_q        <= '0;
         phi_q       <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         plb_dout_q  <= '0;
         hst_dout_q  <= '0;
         hst_ack_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         cnt_q       <= cnt_d;
         stage_val_q <= stage_val_d;
         vlr_q       <= vlr_d;
         alpha_q     <= alpha_d;
         rk_q        <= rk_d;
         phi_q       <= phi_d;
         done_q      <= done_d;
         err_q       <= err_d;
         plb_dout_q  <= plb_dout_d;
         hst_dout_q  <= hst_dout_d;
         hst_ack_q   <= hst_ack_d;
      end
   end

endmodule

// File: doc/plb_stage_host.md
Name: plb_stage_host

Overview:
PS-side counterpart of the EKF-SLAM accelerator top level. It has two functions:
- Stage initiator: drives the stage_val handshake and the predict/update operands (vlr, alpha, rk, phi) that the accelerator core consumes, and reports completion or timeout.
- BRAM responder: services the core's PLB BRAM master port (PLB_en/we/addr/din -> PLB_dout). A second host port lets the PS or a testbench preload and read back the covariance/state memory.
It replaces the simulation-only BRAM model and lets a bench or the PS stub drive complete stage sequences.

Parameters:
PLB_AW, 10, word-address width of internal memory (depth 2^PLB_AW words)
DW, 32, data width of memory and operands
TO_W, 16, width of the stage timeout counter

Ports:
clk  input  1  system clock
sys_rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  stage command valid
cmd_ready  output  1  stage command accepted when valid&ready
cmd_stage  input  2  0=predict, 1=newlm, 2=update, 3=illegal
cmd_a  input  DW  predict: vlr; newlm/update: rk
cmd_b  input  DW  predict: alpha; newlm/update: phi
timeout_lim  input  TO_W  max wait cycles; 0 disables timeout
stage_val  output  3  one-hot stage request to core (bit0 predict, bit1 newlm, bit2 update)
stage_rdy  input  3  per-stage completion level from core
vlr, alpha, rk, phi  output  DW each  held operands to core
busy  output  1  FSM not IDLE
done  output  1  one-cycle pulse: stage completed
err  output  1  one-cycle pulse: illegal command or timeout
PLB_en  input  1  core BRAM enable
PLB_we  input  1  core BRAM write enable
PLB_addr  input  32  core word address; only [PLB_AW-1:0] used, upper bits ignored (aliasing)
PLB_din  input  DW  core write data
PLB_dout  output  DW  core read data
hst_en  input  1  host access request (hold until hst_ack)
hst_we  input  1  host write
hst_addr  input  PLB_AW  host word address
hst_din  input  DW  host write data
hst_dout  output  DW  host read data, valid with hst_ack
hst_ack  output  1  one-cycle pulse: host access completed

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE; stage_val=0, operands=0, done=err=busy=0, PLB_dout=0, hst_dout=0, hst_ack=0, wait counter=0. Memory contents are not reset. Reset mid-stage drops stage_val to 0 immediately.
- FSM IDLE: cmd_ready=1.
  - On accept with cmd_stage=3: err=1 next cycle; stay IDLE; operands unchanged.
  - On accept with a legal stage: latch cmd_a/cmd_b into the selected operand pair (predict -> vlr/alpha; newlm or update -> rk/phi); the other pair holds. stage_val<=onehot(cmd_stage), cnt<=0, go to WAIT. stage_val and operands change on the same edge.
- FSM WAIT: cmd_ready=0; stage_val held.
  - If stage_rdy[sel]=1: stage_val<=0, done=1 next cycle, go to GAP.
  - Else if timeout_lim!=0 and cnt==timeout_lim-1: stage_val<=0, err=1 next cycle, go to GAP.
  - Else cnt++.
  - Non-selected stage_rdy bits are ignored. stage_rdy already high on the first WAIT cycle completes immediately (minimum 1 cycle of stage_val).
- FSM GAP: stage_val=0, cmd_ready=0. Leave for IDLE only when stage_rdy[sel]=0 (return-to-zero), which guarantees at least one idle cycle between requests.
- busy=1 in WAIT and GAP.
- Memory, core port (priority):
  - PLB_en&PLB_we writes PLB_din at the edge.
  - PLB_en&!PLB_we registers mem[addr] into PLB_dout; read latency is 1 cycle.
  - PLB_dout holds its last value otherwise, including during writes (read-first, no write-through).
- Memory, host port: a request is granted in a cycle where hst_en=1 and PLB_en=0. It performs the write or registered read, and hst_ack=1 next cycle with hst_dout valid. hst_dout holds otherwise. A host held off by continuous PLB_en waits indefinitely.
- Same-address core write then core read on the next cycle returns the new data.

Test Plan:
- Reset: sys_rst_n=0 mid-WAIT of predict -> stage_val=0 within the same cycle; after release all outputs are 0 and busy=0.
- Predict: cmd_stage=0, cmd_a=0x00010000, cmd_b=0x00008000 -> vlr/alpha hold these values, stage_val=3'b001. Core raises stage_rdy[0] after 20 cycles -> stage_val=0 and done pulses once. FSM stays in GAP until stage_rdy[0] falls, then cmd_ready=1.
- Timeout: cmd_stage=2, timeout_lim=5, stage_rdy held 0 -> stage_val high exactly 5 cycles, then err pulses, done=0. Repeating with timeout_lim=0 keeps stage_val high for 1000 cycles.
- Illegal and wrong-bit: cmd_stage=3 -> err pulse, stage_val stays 0, operands unchanged. cmd_stage=1 with only stage_rdy[2] asserted -> no done.
- BRAM core port: write 0xDEADBEEF to addr 0x005, then read addr 0x405 (aliasing with PLB_AW=10) -> PLB_dout=0xDEADBEEF one cycle after the read enable. During a write, PLB_dout is unchanged.
- Arbitration: hst_en read of addr 7 asserted while PLB_en is held 3 cycles -> hst_ack arrives on the 5th cycle (grant in the 4th cycle, the first with PLB_en=0), hst_dout=mem[7]. A host write of 0x12345678 to addr 9 followed by a core read of addr 9 returns 0x12345678.
